mode_ind_enc: RTL and testbench

Mode indicator encoder: the return path of the DIP-switch decoder. It accepts a 4-bit mode code (1–4 valid, 0 blank, anything else an error) over a valid/ready handshake and drives the 4-bit one-hot mode LEDs. It adds an acknowledge flash on every mode change and a blink pattern for invalid codes. It sits between the mode-select logic and the board LED pins.

---
 rtl/mode_ind_enc_if.sv | 19 +
 rtl/mode_ind_enc.sv | 166 ++++++++++++++++
 tb/tb_mode_ind_enc.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mode_ind_enc_if.sv
// Code handshake between the mode-select logic and the mode LED encoder.
// Transfer happens on a cycle where code_valid_i and code_ready_o are both high.
interface mode_ind_enc_if;
    logic [3:0] code_i;
    logic       code_valid_i;
    logic       code_ready_o;

    modport master (
        output code_i,
        output code_valid_i,
        input  code_ready_o
    );

    modport slave (
        input  code_i,
        input  code_valid_i,
        output code_ready_o
    );
endinterface

// File: rtl/mode_ind_enc.sv
// Mode LED encoder: one-hot mode display, change-acknowledge flash, error blink.
// Define MODE_IND_ACK_EN to build the acknowledge flash states and flash counter.
module mode_ind_enc #(
    parameter int unsigned BLINK_DIV   = 12_500_000,
    parameter int unsigned ACK_FLASHES = 2
) (
    input  logic           clk,
    input  logic           rst,
    mode_ind_enc_if.slave  bus,
    output logic [3:0]     led_o,
    output logic           err_o
);

    localparam int unsigned CNT_W = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    typedef enum logic [2:0] {
        SHOW,
        ACK_ON,
        ACK_OFF,
        ERR_ON,
        ERR_OFF
    } state_t;

    if (BLINK_DIV < 2 || ACK_FLASHES < 1) begin : g_bad_cfg
        $error("mode_ind_enc: BLINK_DIV must be >= 2 and ACK_FLASHES >= 1");
    end

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       cur;
    logic [3:0]       cur_nxt;
    logic [3:0]       led_nxt;
    logic             xfer;
    logic             phase_end;
    logic             enter;

`ifdef MODE_IND_ACK_EN
    localparam int unsigned FL_W = $clog2(ACK_FLASHES + 1);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(ACK_FLASHES - 1);

    logic [FL_W-1:0] flash;
    logic [FL_W-1:0] flash_nxt;
    logic            ready_q;

    assign bus.code_ready_o = ready_q;
`else
    assign bus.code_ready_o = 1'b1;
`endif

    assign xfer      = bus.code_valid_i & bus.code_ready_o;
    assign phase_end = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SHOW;
            cnt   <= '0;
            cur   <= '0;
            led_o <= 4'b0000;
            err_o <= 1'b0;
`ifdef MODE_IND_ACK_EN
            flash   <= '0;
            ready_q <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cur   <= cur_nxt;
            led_o <= led_nxt;
            err_o <= (cur > 4'd4);
`ifdef MODE_IND_ACK_EN
            flash   <= flash_nxt;
            ready_q <= !(state == ACK_ON || state == ACK_OFF);
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        enter     = 1'b0;
`ifdef MODE_IND_ACK_EN
        flash_nxt = flash;
`endif
        unique case (state)
            SHOW: ;
`ifdef MODE_IND_ACK_EN
            ACK_ON: begin
                if (phase_end) begin
                    state_nxt = ACK_OFF;
                    enter     = 1'b1;
                end
            end
            ACK_OFF: begin
                if (phase_end) begin
                    enter = 1'b1;
                    if (flash == FL_LAST) begin
                        state_nxt = SHOW;
                    end else begin
                        state_nxt = ACK_ON;
                        flash_nxt = flash + 1'b1;
                    end
                end
            end
`endif
            ERR_ON: begin
                if (phase_end) begin
                    state_nxt = ERR_OFF;
                    enter     = 1'b1;
                end
            end
            ERR_OFF: begin
                if (phase_end) begin
                    state_nxt = ERR_ON;
                    enter     = 1'b1;
                end
            end
            default: state_nxt = SHOW;
        endcase

        // A re-sent identical code must not restart the blink phase.
        if (xfer && bus.code_i != cur) begin
            cur_nxt = bus.code_i;
            enter   = 1'b1;
            if (bus.code_i > 4'd4) begin
                state_nxt = ERR_ON;
            end else begin
`ifdef MODE_IND_ACK_EN
                state_nxt = ACK_ON;
                flash_nxt = '0;
`else
                state_nxt = SHOW;
`endif
            end
        end

        if (enter || state_nxt == SHOW) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_comb begin
        led_nxt = 4'b0000;
        unique case (state)
            SHOW: begin
                unique case (cur)
                    4'd1:    led_nxt = 4'b0001;
                    4'd2:    led_nxt = 4'b0010;
                    4'd3:    led_nxt = 4'b0100;
                    4'd4:    led_nxt = 4'b1000;
                    default: led_nxt = 4'b0000;
                endcase
            end
`ifdef MODE_IND_ACK_EN
            ACK_ON:  led_nxt = 4'b1111;
`endif
            ERR_ON:  led_nxt = 4'b1111;
            default: led_nxt = 4'b0000;
        endcase
    end

endmodule

// File: tb/tb_mode_ind_enc.sv
// Directed bench for mode_ind_enc with BLINK_DIV=4, ACK_FLASHES=2.
// Expectations follow MODE_IND_ACK_EN so the same bench covers both builds.
module tb_mode_ind_enc;
    localparam int DIV = 4;
    localparam int FL  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] led;
    logic       err;
    int         n_chk  = 0;
    int         n_fail = 0;

    mode_ind_enc_if bus();

    mode_ind_enc #(
        .BLINK_DIV  (DIV),
        .ACK_FLASHES(FL)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .led_o(led),
        .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] c);
        bus.code_i       = c;
        bus.code_valid_i = 1'b1;
        tick();
        bus.code_valid_i = 1'b0;
    endtask

    // Entered right after the transfer edge; leaves after the first SHOW cycle.
    task automatic ack_seq(input logic [3:0] fin, input logic [3:0] hold,
                           input bit use_hold);
`ifdef MODE_IND_ACK_EN
        for (int i = 0; i < 2 * DIV * FL; i++) begin
            if (use_hold && i == 2) begin
                bus.code_i       = hold;
                bus.code_valid_i = 1'b1;
            end
            tick();
            chk("ack_led", led, ((i / DIV) % 2 == 0) ? 4'hF : 4'h0);
            chk("ack_rdy", {3'b0, bus.code_ready_o}, 4'd0);
        end
`else
        if (use_hold) bus.code_i = hold;
`endif
        tick();
        chk("final_led", led, fin);
        chk("final_rdy", {3'b0, bus.code_ready_o}, 4'd1);
        chk("final_err", {3'b0, err}, 4'd0);
    endtask

    initial begin
        bus.code_i       = 4'd0;
        bus.code_valid_i = 1'b0;
        rst              = 1'b1;
        tick();
        tick();
        chk("rst_led", led, 4'b0000);
        chk("rst_err", {3'b0, err}, 4'd0);
        chk("rst_rdy", {3'b0, bus.code_ready_o}, 4'd1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_led", led, 4'b0000);
            chk("idle_err", {3'b0, err}, 4'd0);
            chk("idle_rdy", {3'b0, bus.code_ready_o}, 4'd1);
        end

        send(4'd3);
        chk("xfer_lat", led, 4'b0000);
        ack_seq(4'b0100, 4'd1, 1'b1);

`ifdef MODE_IND_ACK_EN
        tick();
        bus.code_valid_i = 1'b0;
        chk("hold_lat", led, 4'b0100);
        ack_seq(4'b0001, 4'd0, 1'b0);
`else
        send(4'd1);
        chk("rdy_tied", {3'b0, bus.code_ready_o}, 4'd1);
        ack_seq(4'b0001, 4'd0, 1'b0);
`endif

        send(4'd15);
        chk("err_lat", {3'b0, err}, 4'd0);
        for (int i = 0; i < 44; i++) begin
            tick();
            chk("blink_led", led, ((i / DIV) % 2 == 0) ? 4'hF : 4'h0);
            chk("blink_err", {3'b0, err}, 4'd1);
            chk("blink_rdy", {3'b0, bus.code_ready_o}, 4'd1);
        end

        send(4'd2);
        chk("err_hold", {3'b0, err}, 4'd1);
        ack_seq(4'b0010, 4'd0, 1'b0);

        send(4'd2);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("same_led", led, 4'b0010);
            chk("same_rdy", {3'b0, bus.code_ready_o}, 4'd1);
        end

        send(4'd9);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("err9_led", led, (i < DIV) ? 4'hF : 4'h0);
        end
        rst              = 1'b1;
        bus.code_i       = 4'd3;
        bus.code_valid_i = 1'b1;
        tick();
        chk("mid_rst_led", led, 4'b0000);
        chk("mid_rst_err", {3'b0, err}, 4'd0);
        chk("mid_rst_rdy", {3'b0, bus.code_ready_o}, 4'd1);
        rst              = 1'b0;
        bus.code_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_led", led, 4'b0000);
            chk("post_rst_err", {3'b0, err}, 4'd0);
        end

        send(4'd4);
        chk("m4_rdy", {3'b0, bus.code_ready_o}, 4'd1);
        ack_seq(4'b1000, 4'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
